// File: rtl/mode_register.sv
// mode_register: multi-function register (load/hold/inc/dec/shift/clear) with carry and zero flag.
// Optional macro REG_SATURATE_EN makes INC/DEC saturate instead of wrapping.
`default_nettype none

module mode_register #(
   parameter int unsigned          WIDTH       = 16,
   parameter int unsigned          STEP        = 1,
   parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
   input  logic             clock,
   input  logic             reg_reset,
   input  logic [WIDTH-1:0] reg_in,
   input  logic             reg_wr,
   input  logic [2:0]       reg_op,
   input  logic             reg_sin,
   output logic [WIDTH-1:0] reg_out,
   output logic             reg_carry,
   output logic             reg_zero
);

   localparam logic [2:0] OP_HOLD  = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;
   localparam logic [2:0] OP_INC   = 3'b010;
   localparam logic [2:0] OP_DEC   = 3'b011;
   localparam logic [2:0] OP_SHL   = 3'b100;
   localparam logic [2:0] OP_SHR   = 3'b101;
   localparam logic [2:0] OP_CLEAR = 3'b110;

   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   logic [WIDTH:0]   inc_sum;
   logic [WIDTH:0]   dec_diff;
   logic [WIDTH-1:0] next_out;
   logic             next_carry;

   // One extra bit captures carry on INC and borrow on DEC.
   assign inc_sum  = {1'b0, reg_out} + {1'b0, STEP_W};
   assign dec_diff = {1'b0, reg_out} - {1'b0, STEP_W};

   always_comb begin
      next_out   = reg_out;
      next_carry = reg_carry;
      case (reg_op)
         OP_HOLD: begin
            next_out   = reg_out;
            next_carry = reg_carry;
         end
         OP_LOAD: begin
            next_out   = reg_in;
            next_carry = 1'b0;
         end
         OP_INC: begin
`ifdef REG_SATURATE_EN
            next_out   = inc_sum[WIDTH] ? {WIDTH{1'b1}} : inc_sum[WIDTH-1:0];
            next_carry = inc_sum[WIDTH];
`else
            next_out   = inc_sum[WIDTH-1:0];
            next_carry = inc_sum[WIDTH];
`endif
         end
         OP_DEC: begin
`ifdef REG_SATURATE_EN
            next_out   = dec_diff[WIDTH] ? {WIDTH{1'b0}} : dec_diff[WIDTH-1:0];
            next_carry = dec_diff[WIDTH];
`else
            next_out   = dec_diff[WIDTH-1:0];
            next_carry = dec_diff[WIDTH];
`endif
         end
         OP_SHL: begin
            next_out   = {reg_out[WIDTH-2:0], reg_sin};
            next_carry = reg_out[WIDTH-1];
         end
         OP_SHR: begin
            next_out   = {reg_sin, reg_out[WIDTH-1:1]};
            next_carry = reg_out[0];
         end
         OP_CLEAR: begin
            next_out   = '0;
            next_carry = 1'b0;
         end
         default: begin
            next_out   = reg_out;
            next_carry = reg_carry;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reg_reset) begin
         reg_out   <= RESET_VALUE;
         reg_carry <= 1'b0;
      end else if (reg_wr) begin
         reg_out   <= reg_in;
         reg_carry <= 1'b0;
      end else begin
         reg_out   <= next_out;
         reg_carry <= next_carry;
      end
   end

   assign reg_zero = (reg_out == '0);

endmodule

`default_nettype wire

// File: tb/tb_mode_register.sv
// tb_mode_register: directed self-checking bench for mode_register (WIDTH=16, STEP=1, RESET_VALUE=0).
`default_nettype none

module tb_mode_register;

   logic        clock = 1'b0;
   logic        reg_reset;
   logic [15:0] reg_in;
   logic        reg_wr;
   logic [2:0]  reg_op;
   logic        reg_sin;
   logic [15:0] reg_out;
   logic        reg_carry;
   logic        reg_zero;

   int errors = 0;
   int checks = 0;

   mode_register #(
      .WIDTH       (16),
      .STEP        (1),
      .RESET_VALUE (16'h0000)
   ) dut (
      .clock     (clock),
      .reg_reset (reg_reset),
      .reg_in    (reg_in),
      .reg_wr    (reg_wr),
      .reg_op    (reg_op),
      .reg_sin   (reg_sin),
      .reg_out   (reg_out),
      .reg_carry (reg_carry),
      .reg_zero  (reg_zero)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one command, let one rising edge pass, then settle before sampling.
   task automatic step(input logic rst, input logic wr, input logic [2:0] op,
                       input logic [15:0] din, input logic sin);
      reg_reset = rst;
      reg_wr    = wr;
      reg_op    = op;
      reg_in    = din;
      reg_sin   = sin;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reg_reset = 1'b0;
      reg_wr    = 1'b0;
      reg_op    = 3'b000;
      reg_in    = 16'h0000;
      reg_sin   = 1'b0;
      #2;

      step(1'b1, 1'b1, 3'b000, 16'h0032, 1'b0);
      check("reset_out", reg_out, 16'h0000);
      check("reset_carry", reg_carry, 1'b0);
      check("reset_zero", reg_zero, 1'b1);

      step(1'b0, 1'b1, 3'b000, 16'h0032, 1'b0);
      check("wr_out", reg_out, 16'h0032);
      check("wr_zero", reg_zero, 1'b0);
      step(1'b0, 1'b0, 3'b000, 16'h1234, 1'b1);
      step(1'b0, 1'b0, 3'b000, 16'h1234, 1'b1);
      step(1'b0, 1'b0, 3'b000, 16'h1234, 1'b1);
      check("hold3_out", reg_out, 16'h0032);

      step(1'b0, 1'b1, 3'b000, 16'hFFFF, 1'b0);
      step(1'b0, 1'b0, 3'b010, 16'h0000, 1'b0);
`ifdef REG_SATURATE_EN
      check("inc_ovf_out", reg_out, 16'hFFFF);
      check("inc_ovf_zero", reg_zero, 1'b0);
`else
      check("inc_ovf_out", reg_out, 16'h0000);
      check("inc_ovf_zero", reg_zero, 1'b1);
`endif
      check("inc_ovf_carry", reg_carry, 1'b1);
      step(1'b0, 1'b0, 3'b000, 16'h5555, 1'b0);
      check("hold_keeps_carry", reg_carry, 1'b1);

      step(1'b0, 1'b0, 3'b001, 16'h0000, 1'b0);
      check("op_load_out", reg_out, 16'h0000);
      check("op_load_carry", reg_carry, 1'b0);
      step(1'b0, 1'b0, 3'b010, 16'h0000, 1'b0);
      check("inc_out", reg_out, 16'h0001);
      check("inc_carry", reg_carry, 1'b0);

      step(1'b0, 1'b0, 3'b110, 16'h0000, 1'b0);
      check("clear_out", reg_out, 16'h0000);
      check("clear_zero", reg_zero, 1'b1);
      step(1'b0, 1'b0, 3'b011, 16'h0000, 1'b0);
`ifdef REG_SATURATE_EN
      check("dec_unf_out", reg_out, 16'h0000);
      check("dec_unf_zero", reg_zero, 1'b1);
`else
      check("dec_unf_out", reg_out, 16'hFFFF);
      check("dec_unf_zero", reg_zero, 1'b0);
`endif
      check("dec_unf_carry", reg_carry, 1'b1);
      step(1'b0, 1'b1, 3'b000, 16'h0005, 1'b0);
      step(1'b0, 1'b0, 3'b011, 16'h0000, 1'b0);
      check("dec_out", reg_out, 16'h0004);
      check("dec_carry", reg_carry, 1'b0);

      step(1'b0, 1'b1, 3'b000, 16'hFD92, 1'b0);
      step(1'b0, 1'b0, 3'b100, 16'h0000, 1'b1);
      check("shl_out", reg_out, 16'hFB25);
      check("shl_carry", reg_carry, 1'b1);
      step(1'b0, 1'b1, 3'b000, 16'h0002, 1'b0);
      step(1'b0, 1'b0, 3'b101, 16'h0000, 1'b1);
      check("shr_sin_out", reg_out, 16'h8001);
      check("shr_sin_carry", reg_carry, 1'b0);
      step(1'b0, 1'b1, 3'b000, 16'hFE13, 1'b0);
      step(1'b0, 1'b0, 3'b101, 16'h0000, 1'b0);
      check("shr_out", reg_out, 16'h7F09);
      check("shr_carry", reg_carry, 1'b1);

      step(1'b0, 1'b1, 3'b010, 16'h0090, 1'b0);
      check("wr_over_op_out", reg_out, 16'h0090);
      check("wr_over_op_carry", reg_carry, 1'b0);
      step(1'b1, 1'b1, 3'b010, 16'h0090, 1'b0);
      check("rst_over_wr_out", reg_out, 16'h0000);

      step(1'b0, 1'b1, 3'b000, 16'hFF03, 1'b0);
      step(1'b0, 1'b0, 3'b010, 16'h0000, 1'b0);
      step(1'b0, 1'b0, 3'b010, 16'h0000, 1'b0);
      check("inc_seq_out", reg_out, 16'hFF05);
      step(1'b1, 1'b0, 3'b010, 16'h0000, 1'b0);
      check("rst_mid_seq_out", reg_out, 16'h0000);
      check("rst_mid_seq_carry", reg_carry, 1'b0);
      step(1'b0, 1'b0, 3'b010, 16'h0000, 1'b0);
      check("resume_inc_out", reg_out, 16'h0001);
      step(1'b0, 1'b0, 3'b111, 16'hABCD, 1'b1);
      check("reserved_out", reg_out, 16'h0001);
      check("reserved_carry", reg_carry, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
